cache_ref_model_pipe: RTL and testbench

Parametrised behavioural reference memory for mem_ss verification. It is the scoreboard golden model that sits beside the cache DUT and shares its core-side request stream. The cache-line geometry, read latency and response depth are configurable. It adds a valid/ready request handshake, a credit-limited read pipeline and a backpressurable response path, so it can model multiple outstanding reads.

---
 rtl/mem_ref_pkg.sv | 28 ++
 rtl/cache_ref_model_pipe_if.sv | 34 +++
 rtl/mem_ref_rsp_fifo.sv | 53 +++++
 rtl/cache_ref_model_pipe.sv | 157 +++++++++++++++
 tb/tb_cache_ref_model_pipe.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ref_pkg.sv
// Shared types and defaults for the behavioural reference memory model.
package mem_ref_pkg;

    typedef enum logic {
        RD_OP = 1'b0,
        WR_OP = 1'b1
    } t_opcode;

    localparam int DEF_ADDR_W       = 20;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_WORDS_PER_CL = 4;
    localparam int DEF_RD_LATENCY   = 1;
    localparam int DEF_RSP_DEPTH    = 4;
    localparam int DEF_REG_ID_W     = 5;

    // Response record at the default geometry.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0]   address;
        logic [DEF_DATA_W-1:0]   data;
        logic [DEF_REG_ID_W-1:0] reg_id;
    } t_ref_rsp;

    // Width of the line index: whatever is left above the byte and word offsets.
    function automatic int line_idx_w(input int addr_w, input int data_w, input int words_per_cl);
        return addr_w - $clog2(data_w / 8) - $clog2(words_per_cl);
    endfunction

endpackage

// File: rtl/cache_ref_model_pipe_if.sv
// Core-side request/response bundle shared by the cache and its reference model.
interface cache_ref_model_pipe_if
    import mem_ref_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_ID_W = DEF_REG_ID_W
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_opcode;
    logic [ADDR_W-1:0]     req_address;
    logic [DATA_W-1:0]     req_data;
    logic [DATA_W/8-1:0]   req_byte_en;
    logic                  req_sign_extend;
    logic [REG_ID_W-1:0]   req_reg_id;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ADDR_W-1:0]     rsp_address;
    logic [DATA_W-1:0]     rsp_data;
    logic [REG_ID_W-1:0]   rsp_reg_id;

    modport master (
        output req_valid, req_opcode, req_address, req_data, req_byte_en,
               req_sign_extend, req_reg_id, rsp_ready,
        input  req_ready, rsp_valid, rsp_address, rsp_data, rsp_reg_id
    );

    modport slave (
        input  req_valid, req_opcode, req_address, req_data, req_byte_en,
               req_sign_extend, req_reg_id, rsp_ready,
        output req_ready, rsp_valid, rsp_address, rsp_data, rsp_reg_id
    );
endinterface

// File: rtl/mem_ref_rsp_fifo.sv
// Generic first-word-fall-through FIFO; the head is visible on pop_data while not empty.
module mem_ref_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_data = mem[rd_ptr];
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Entry storage; contents need no reset since empty gates the head.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
endmodule

// File: rtl/cache_ref_model_pipe.sv
// Golden reference memory: byte-enabled writes, sign-extending reads, credit-limited
// read pipeline of RD_LATENCY cycles feeding an in-order, backpressurable response FIFO.
module cache_ref_model_pipe
    import mem_ref_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int WORDS_PER_CL = DEF_WORDS_PER_CL,
    parameter int RD_LATENCY   = DEF_RD_LATENCY,
    parameter int RSP_DEPTH    = DEF_RSP_DEPTH,
    parameter int REG_ID_W     = DEF_REG_ID_W
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_ref_model_pipe_if.slave bus
);
    localparam int BYTES      = DATA_W / 8;
    localparam int BYTE_OFF_W = $clog2(BYTES);
    localparam int WORD_OFF_W = $clog2(WORDS_PER_CL);
    localparam int LINE_W     = line_idx_w(ADDR_W, DATA_W, WORDS_PER_CL);
    localparam int NUM_CL     = 1 << LINE_W;
    localparam int CL_W       = WORDS_PER_CL * DATA_W;
    localparam int ENT_W      = ADDR_W + DATA_W + REG_ID_W;
    localparam int CNT_W      = $clog2(RSP_DEPTH + 1);

    logic [CL_W-1:0]   mem [NUM_CL];

    logic              acc;
    logic              rd_acc_p0;
    logic              wr_acc_p0;
    logic [LINE_W-1:0] line_p0;
    logic [ADDR_W-1:0] word_p0;
    logic [CL_W-1:0]   line_data_p0;
    logic [DATA_W-1:0] stored_p0;
    logic              vld_p0;
    logic [ENT_W-1:0]  ent_p0;

    logic              push;
    logic [ENT_W-1:0]  push_ent;
    logic [ENT_W-1:0]  head_ent;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  credit_cnt;

    // Disabled bytes either zero or replicate the top bit of the byte just below,
    // so a run of disabled bytes propagates the sign of the highest enabled byte.
    function automatic logic [DATA_W-1:0] rd_format(input logic [DATA_W-1:0] stored,
                                                    input logic [BYTES-1:0]  be,
                                                    input logic              sx);
        logic [DATA_W-1:0] res;
        res = '0;
        if (be[0]) res[7:0] = stored[7:0];
        for (int i = 1; i < BYTES; i++) begin
            if (be[i])   res[i*8 +: 8] = stored[i*8 +: 8];
            else if (sx) res[i*8 +: 8] = {8{res[i*8-1]}};
        end
        return res;
    endfunction

    // ---- stage p0: acceptance, address split, combinational read of storage
    assign bus.req_ready = (credit_cnt < CNT_W'(RSP_DEPTH));
    assign acc           = bus.req_valid && bus.req_ready;
    assign rd_acc_p0     = acc && (t_opcode'(bus.req_opcode) == RD_OP);
    assign wr_acc_p0     = acc && (t_opcode'(bus.req_opcode) == WR_OP);
    assign line_p0       = LINE_W'(bus.req_address >> (BYTE_OFF_W + WORD_OFF_W));
    assign word_p0       = (bus.req_address >> BYTE_OFF_W) & ADDR_W'(WORDS_PER_CL - 1);
    assign line_data_p0  = mem[line_p0];
    assign stored_p0     = DATA_W'(line_data_p0 >> (word_p0 * DATA_W));
    assign vld_p0        = rd_acc_p0;
    assign ent_p0        = {bus.req_address,
                            rd_format(stored_p0, bus.req_byte_en, bus.req_sign_extend),
                            bus.req_reg_id};

    // Storage: cleared on reset, enabled bytes of the addressed word updated on write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CL; i++) mem[i] <= '0;
        end else if (wr_acc_p0) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.req_byte_en[b])
                    mem[line_p0][word_p0*DATA_W + b*8 +: 8] <= bus.req_data[b*8 +: 8];
            end
        end
    end

    // ---- stages p1..p(RD_LATENCY-1): delay line; the FIFO register is the final stage
    generate
        if (RD_LATENCY == 1) begin : g_direct
            assign push     = vld_p0;
            assign push_ent = ent_p0;
        end else begin : g_pipe
            logic             vld_pn [RD_LATENCY-1];
            logic [ENT_W-1:0] ent_pn [RD_LATENCY-1];

            // Valid shift register; reset discards every in-flight read.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < RD_LATENCY - 1; k++) vld_pn[k] <= 1'b0;
                end else begin
                    vld_pn[0] <= vld_p0;
                    for (int k = 1; k < RD_LATENCY - 1; k++) vld_pn[k] <= vld_pn[k-1];
                end
            end

            // Payload shift register travelling beside the valid bits.
            always_ff @(posedge clk) begin
                ent_pn[0] <= ent_p0;
                for (int k = 1; k < RD_LATENCY - 1; k++) ent_pn[k] <= ent_pn[k-1];
            end

            assign push     = vld_pn[RD_LATENCY-2];
            assign push_ent = ent_pn[RD_LATENCY-2];
        end
    endgenerate

    // ---- response stage: in-order FWFT buffer, head gated to zero when empty
    mem_ref_rsp_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_ent),
        .pop       (pop),
        .pop_data  (head_ent),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.rsp_valid = !fifo_empty;
    assign pop           = bus.rsp_valid && bus.rsp_ready;
    assign {bus.rsp_address, bus.rsp_data, bus.rsp_reg_id} = fifo_empty ? '0 : head_ent;

    // Credits count reads in the pipeline plus the FIFO, so the FIFO cannot overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt <= '0;
        end else if (rd_acc_p0 && !pop) begin
            credit_cnt <= credit_cnt + 1'b1;
        end else if (pop && !rd_acc_p0) begin
            credit_cnt <= credit_cnt - 1'b1;
        end
    end

    a_req_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.req_valid && !bus.req_ready) |=>
            (bus.req_valid && $stable(bus.req_opcode) && $stable(bus.req_address) &&
             $stable(bus.req_data) && $stable(bus.req_byte_en) &&
             $stable(bus.req_sign_extend) && $stable(bus.req_reg_id)));
    a_credit_max:  assert property (@(posedge clk) disable iff (rst) credit_cnt <= CNT_W'(RSP_DEPTH));
    a_fifo_le_cr:  assert property (@(posedge clk) disable iff (rst) fifo_count <= credit_cnt);
    a_push_full:   assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));
endmodule

// File: tb/tb_cache_ref_model_pipe.sv
// Bench for the reference memory: vector table plus backpressure, streaming and reset sequences.
module tb_cache_ref_model_pipe;
    import mem_ref_pkg::*;

    localparam int RD_LAT = 3;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic        op;
        logic [19:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        sx;
        logic [4:0]  id;
        logic [31:0] exp;
    } t_vec;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_ref_model_pipe_if #(
        .ADDR_W   (DEF_ADDR_W),
        .DATA_W   (DEF_DATA_W),
        .REG_ID_W (DEF_REG_ID_W)
    ) bus ();

    cache_ref_model_pipe #(
        .ADDR_W       (DEF_ADDR_W),
        .DATA_W       (DEF_DATA_W),
        .WORDS_PER_CL (DEF_WORDS_PER_CL),
        .RD_LATENCY   (RD_LAT),
        .RSP_DEPTH    (DEPTH),
        .REG_ID_W     (DEF_REG_ID_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    t_ref_rsp    sb[$];
    int          pop_cyc[$];
    logic [4:0]  pop_id[$];
    t_ref_rsp    mon_e;
    t_vec        vecs[$];
    int          acc_q[16];
    int          acc5;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic t_vec mk(input logic op, input logic [19:0] a, input logic [31:0] d,
                                input logic [3:0] be, input logic sx, input logic [4:0] id,
                                input logic [31:0] exp);
        t_vec v;
        v.op = op; v.addr = a; v.data = d; v.be = be; v.sx = sx; v.id = id; v.exp = exp;
        return v;
    endfunction

    // Scoreboard: every accepted response is compared with the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            pop_cyc.push_back(cyc);
            pop_id.push_back(bus.rsp_reg_id);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected got id %0d expected no response", bus.rsp_reg_id);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_address", 64'(bus.rsp_address), 64'(mon_e.address));
                chk("rsp_data",    64'(bus.rsp_data),    64'(mon_e.data));
                chk("rsp_reg_id",  64'(bus.rsp_reg_id),  64'(mon_e.reg_id));
            end
        end
    end

    // Present one request, hold it until accepted, record the acceptance cycle.
    task automatic send(input t_vec v, output int acc);
        int n;
        t_ref_rsp e;
        bus.req_opcode      = v.op;
        bus.req_address     = v.addr;
        bus.req_data        = v.data;
        bus.req_byte_en     = v.be;
        bus.req_sign_extend = v.sx;
        bus.req_reg_id      = v.id;
        bus.req_valid       = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout got req_ready 0 expected 1 within 100 cycles");
            acc = -1;
        end else if (v.op == RD_OP) begin
            e.address = v.addr;
            e.data    = v.exp;
            e.reg_id  = v.id;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_opcode = 1'b0; bus.req_address = '0; bus.req_data = '0;
        bus.req_byte_en = '0; bus.req_sign_extend = 1'b0; bus.req_reg_id = '0; bus.rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid",   64'(bus.rsp_valid),   64'd0);
        chk("reset_req_ready",   64'(bus.req_ready),   64'd1);
        chk("reset_rsp_data",    64'(bus.rsp_data),    64'd0);
        chk("reset_rsp_address", 64'(bus.rsp_address), 64'd0);
        chk("reset_rsp_reg_id",  64'(bus.rsp_reg_id),  64'd0);
        @(posedge clk);
        #1;

        // First read after reset: valid exactly RD_LAT cycles after acceptance.
        bus.rsp_ready = 1'b1;
        send(mk(1'b0, 20'h00010, 32'h0, 4'hF, 1'b0, 5'd7, 32'h0000_0000), acc_q[0]);
        @(negedge clk); chk("latency_t1", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk); chk("latency_t2", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk); chk("latency_t3", 64'(bus.rsp_valid), 64'd1);
        @(posedge clk);
        #1;
        drain("drain_latency");

        // Table of writes and reads; write-then-read pairs are issued back to back.
        vecs.push_back(mk(1'b1, 20'h00024, 32'hDEAD_BEEF, 4'hF, 1'b0, 5'd0,  32'h0));
        vecs.push_back(mk(1'b0, 20'h00024, 32'h0,         4'h1, 1'b1, 5'd1,  32'hFFFF_FFEF));
        vecs.push_back(mk(1'b0, 20'h00024, 32'h0,         4'h3, 1'b0, 5'd2,  32'h0000_BEEF));
        vecs.push_back(mk(1'b1, 20'h00024, 32'h0000_00AA, 4'h1, 1'b0, 5'd0,  32'h0));
        vecs.push_back(mk(1'b0, 20'h00024, 32'h0,         4'hF, 1'b0, 5'd3,  32'hDEAD_BEAA));
        vecs.push_back(mk(1'b0, 20'h00024, 32'h0,         4'h2, 1'b1, 5'd4,  32'hFFFF_BE00));
        vecs.push_back(mk(1'b0, 20'h00024, 32'h0,         4'h4, 1'b1, 5'd5,  32'hFFAD_0000));
        vecs.push_back(mk(1'b0, 20'h00024, 32'h0,         4'h2, 1'b0, 5'd6,  32'h0000_BE00));
        vecs.push_back(mk(1'b1, 20'h00028, 32'h1234_5678, 4'hF, 1'b0, 5'd0,  32'h0));
        vecs.push_back(mk(1'b0, 20'h00028, 32'h0,         4'h8, 1'b1, 5'd8,  32'h1200_0000));
        vecs.push_back(mk(1'b0, 20'h00024, 32'h0,         4'hF, 1'b0, 5'd9,  32'hDEAD_BEAA));
        vecs.push_back(mk(1'b0, 20'h00025, 32'h0,         4'hF, 1'b0, 5'd10, 32'hDEAD_BEAA));
        vecs.push_back(mk(1'b1, 20'h00034, 32'h0000_0080, 4'hF, 1'b0, 5'd0,  32'h0));
        vecs.push_back(mk(1'b0, 20'h00034, 32'h0,         4'h1, 1'b1, 5'd11, 32'hFFFF_FF80));
        vecs.push_back(mk(1'b0, 20'h00038, 32'h0,         4'hF, 1'b1, 5'd12, 32'h0000_0000));
        vecs.push_back(mk(1'b1, 20'h10024, 32'h0000_0055, 4'hF, 1'b0, 5'd0,  32'h0));
        vecs.push_back(mk(1'b0, 20'h00024, 32'h0,         4'hF, 1'b0, 5'd13, 32'hDEAD_BEAA));
        vecs.push_back(mk(1'b0, 20'h10024, 32'h0,         4'hF, 1'b0, 5'd14, 32'h0000_0055));
        for (int i = 0; i < vecs.size(); i++) send(vecs[i], acc_q[0]);
        drain("drain_table");

        // Backpressure: four reads fill the credits, the fifth waits for the first pop.
        bus.rsp_ready = 1'b0;
        pop_cyc.delete();
        pop_id.delete();
        for (int k = 0; k < 4; k++)
            send(mk(1'b0, 20'h00024, 32'h0, 4'hF, 1'b0, 5'(k + 1), 32'hDEAD_BEAA), acc_q[k]);
        for (int k = 1; k < 4; k++) chk("bp_accept_back_to_back", 64'(acc_q[k] - acc_q[0]), 64'(k));
        @(negedge clk);
        chk("bp_req_ready_low", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        fork
            send(mk(1'b0, 20'h00028, 32'h0, 4'hF, 1'b0, 5'd5, 32'h1234_5678), acc5);
            begin
                @(negedge clk);
                chk("bp_hold_reg_id", 64'(bus.rsp_reg_id), 64'd1);
                repeat (3) @(negedge clk);
                chk("bp_hold_reg_id_later", 64'(bus.rsp_reg_id), 64'd1);
                chk("bp_hold_data_later",   64'(bus.rsp_data),   64'hDEAD_BEAA);
                chk("bp_hold_valid",        64'(bus.rsp_valid),  64'd1);
                @(posedge clk);
                #1 bus.rsp_ready = 1'b1;
            end
        join
        drain("drain_backpressure");
        chk("bp_pop_count", 64'(pop_id.size()), 64'd5);
        if (pop_cyc.size() == 5) begin
            for (int k = 1; k < 4; k++) chk("bp_pop_consecutive", 64'(pop_cyc[k] - pop_cyc[0]), 64'(k));
            chk("bp_read5_after_first_pop",
                64'((acc5 >= pop_cyc[0]) && (acc5 <= pop_cyc[0] + 1)), 64'd1);
            chk("bp_read5_last", 64'(pop_cyc[4] > pop_cyc[3]), 64'd1);
        end

        // Streaming: with the consumer always ready, one read per cycle in and out.
        for (int k = 0; k < 8; k++)
            send(mk(1'b1, 20'h00100 + 20'(4 * k), 32'h1111_1111 * 32'(k + 1), 4'hF, 1'b0, 5'd0, 32'h0),
                 acc_q[0]);
        pop_cyc.delete();
        pop_id.delete();
        for (int k = 0; k < 12; k++)
            send(mk(1'b0, 20'h00100 + 20'(4 * (k % 8)), 32'h0, 4'hF, 1'b0, 5'(k + 16),
                    32'h1111_1111 * 32'((k % 8) + 1)), acc_q[k]);
        drain("drain_stream");
        for (int k = 1; k < 12; k++) chk("stream_accept", 64'(acc_q[k] - acc_q[0]), 64'(k));
        chk("stream_pop_count", 64'(pop_cyc.size()), 64'd12);
        if (pop_cyc.size() == 12) begin
            for (int k = 1; k < 12; k++) chk("stream_pop", 64'(pop_cyc[k] - pop_cyc[0]), 64'(k));
        end

        // Mid-operation reset: outstanding reads vanish, storage and credits return to zero.
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            send(mk(1'b0, 20'h00024, 32'h0, 4'hF, 1'b0, 5'(k + 1), 32'hDEAD_BEAA), acc_q[0]);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rst_no_stale_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        send(mk(1'b0, 20'h00024, 32'h0, 4'hF, 1'b0, 5'd21, 32'h0), acc_q[0]);
        send(mk(1'b0, 20'h00028, 32'h0, 4'hF, 1'b0, 5'd22, 32'h0), acc_q[1]);
        send(mk(1'b0, 20'h10024, 32'h0, 4'hF, 1'b0, 5'd23, 32'h0), acc_q[2]);
        send(mk(1'b0, 20'h00100, 32'h0, 4'hF, 1'b0, 5'd24, 32'h0), acc_q[3]);
        for (int k = 1; k < 4; k++) chk("rst_credit_restored", 64'(acc_q[k] - acc_q[0]), 64'(k));
        @(negedge clk);
        chk("rst_credit_full", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        drain("drain_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
